// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two requesters.
// Operands are registered onto the ALU, and the result returns over a valid/ready port.
module alu_arbiter #(
    parameter int REGISTER_LEN = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [2:0]              req0_op,
    input  logic [3:0]              req0_cal,
    input  logic [REGISTER_LEN-1:0] req0_a,
    input  logic [REGISTER_LEN-1:0] req0_b,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [2:0]              req1_op,
    input  logic [3:0]              req1_cal,
    input  logic [REGISTER_LEN-1:0] req1_a,
    input  logic [REGISTER_LEN-1:0] req1_b,
    output logic [2:0]              alu_op,
    output logic [3:0]              alu_cal,
    output logic [REGISTER_LEN-1:0] alu_a,
    output logic [REGISTER_LEN-1:0] alu_b,
    input  logic [REGISTER_LEN-1:0] alu_r,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [REGISTER_LEN-1:0] rsp_data,
    output logic                    rsp_id,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   grant0;
    logic   grant1;

    // Ready is a combinational grant so a withdrawn request is never granted.
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        state_nxt = state;
        unique case (state)
            IDLE: begin
                grant0 = req0_valid && (!req1_valid || last_grant);
                grant1 = req1_valid && (!req0_valid || !last_grant);
                if (grant0 || grant1)
                    state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            alu_op     <= '0;
            alu_cal    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (1'b1)
                grant0: begin
                    alu_op     <= req0_op;
                    alu_cal    <= req0_cal;
                    alu_a      <= req0_a;
                    alu_b      <= req0_b;
                    rsp_id     <= 1'b0;
                    last_grant <= 1'b0;
                end
                grant1: begin
                    alu_op     <= req1_op;
                    alu_cal    <= req1_cal;
                    alu_a      <= req1_a;
                    alu_b      <= req1_b;
                    rsp_id     <= 1'b1;
                    last_grant <= 1'b1;
                end
                default: ;
            endcase
            if (state == EXEC) begin
                rsp_data  <= alu_r;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready)
                rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors for the ALU arbiter with a stub ALU beside it.
// Covers grant order, latency, stall, wrap results and reset mid-operation.
module tb_alu_arbiter;

    localparam int RL = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [2:0]    req0_op, req1_op, alu_op;
    logic [3:0]    req0_cal, req1_cal, alu_cal;
    logic [RL-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [RL-1:0] alu_a, alu_b, alu_r;
    logic          rsp_valid, rsp_ready, rsp_id, busy;
    logic [RL-1:0] rsp_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.REGISTER_LEN(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_cal(req0_cal),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_cal(req1_cal),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_cal(alu_cal),
        .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    // Stub ALU: opcode meanings chosen to match the hand-computed results.
    always_comb begin
        alu_r = '0;
        case (alu_op)
            3'b000: alu_r = alu_a & alu_b;
            3'b001: alu_r = {{(RL-1){1'b0}}, (alu_a < alu_b)};
            3'b010: alu_r = alu_a + {6'b0, alu_cal};
            3'b011: alu_r = alu_a - {6'b0, alu_cal};
            3'b100: alu_r = alu_a + alu_b;
            3'b101: alu_r = alu_a - alu_b;
            3'b110: alu_r = alu_a | alu_b;
            default: alu_r = alu_a ^ alu_b;
        endcase
    end

    typedef struct {
        logic          v0;
        logic [2:0]    op0;
        logic [3:0]    cal0;
        logic [RL-1:0] a0, b0;
        logic          v1;
        logic [2:0]    op1;
        logic [3:0]    cal1;
        logic [RL-1:0] a1, b1;
        int            id;
        logic [RL-1:0] data;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(output int id);
        id = -1;
        for (int i = 0; i < 20; i++) begin
            if (req0_ready || req1_ready) begin
                chk("one_ready", {31'b0, req0_ready && req1_ready}, 0);
                id = req1_ready ? 1 : 0;
                return;
            end
            @(negedge clk);
        end
        chk("grant_timeout", 1, 0);
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_op = v.op0; req0_cal = v.cal0;
        req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_op = v.op1; req1_cal = v.cal1;
        req1_a = v.a1; req1_b = v.b1;
    endtask

    task automatic run_vec(input vec_t v);
        int id;
        drive(v);
        rsp_ready = 1'b1;
        #1;
        wait_grant(id);
        chk("grant_id", id, v.id);
        @(posedge clk); #1;
        if (id == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
        chk("alu_a", alu_a, (v.id == 0) ? v.a0 : v.a1);
        chk("alu_op", alu_op, (v.id == 0) ? v.op0 : v.op1);
        @(negedge clk);
        chk("rsp_early", rsp_valid, 0);
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, v.data);
        chk("rsp_id", rsp_id, v.v1 && v.id == 1);
        @(negedge clk);
        chk("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int id, last_cyc;
        vec_t v;
        tbl[0] = '{1'b1, 3'b010, 4'd2, 10'd7, 10'd0,
                   1'b1, 3'b101, 4'd0, 10'd4, 10'd1, 0, 10'd9};
        tbl[1] = '{1'b0, 3'b010, 4'd2, 10'd7, 10'd0,
                   1'b1, 3'b101, 4'd0, 10'd4, 10'd1, 1, 10'd3};
        tbl[2] = '{1'b1, 3'b100, 4'd0, 10'd3, 10'd5,
                   1'b0, 3'b000, 4'd0, 10'd0, 10'd0, 0, 10'd8};
        tbl[3] = '{1'b0, 3'b000, 4'd0, 10'd0, 10'd0,
                   1'b1, 3'b011, 4'd1, 10'd0, 10'd0, 1, 10'h3FF};
        tbl[4] = '{1'b1, 3'b001, 4'd0, 10'd2, 10'd9,
                   1'b0, 3'b000, 4'd0, 10'd0, 10'd0, 0, 10'd1};
        tbl[5] = '{1'b1, 3'b100, 4'd0, 10'h3FF, 10'd2,
                   1'b1, 3'b111, 4'd0, 10'h0F0, 10'h0FF, 1, 10'h00F};
        tbl[6] = '{1'b1, 3'b100, 4'd0, 10'h3FF, 10'd2,
                   1'b0, 3'b000, 4'd0, 10'd0, 10'd0, 0, 10'd1};
        tbl[7] = '{1'b0, 3'b000, 4'd0, 10'd0, 10'd0,
                   1'b1, 3'b110, 4'd0, 10'h200, 10'h001, 1, 10'h201};

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        v = '{1'b0, 3'd0, 4'd0, 10'd0, 10'd0, 1'b0, 3'd0, 4'd0, 10'd0, 10'd0, 0, 10'd0};
        drive(v);
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu", {alu_op, alu_cal, alu_a, alu_b}, 0);
        chk("rst_rsp", {rsp_data, rsp_id}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Both requesters held valid: grants alternate, one op per 3 cycles.
        req0_valid = 1'b1; req0_op = 3'b100; req0_a = 10'd1; req0_b = 10'd1;
        req1_valid = 1'b1; req1_op = 3'b100; req1_a = 10'd5; req1_b = 10'd5;
        #1;
        last_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(id);
            chk("alt_id", id, k % 2);
            if (k > 0) chk("alt_gap", cyc - last_cyc, 3);
            last_cyc = cyc;
            repeat (2) @(negedge clk);
            chk("alt_data", rsp_data, (k % 2) ? 10 : 2);
            chk("alt_rsp_id", rsp_id, k % 2);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);

        // Response stall with a second request waiting.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b100; req0_a = 10'd10; req0_b = 10'd20;
        #1;
        wait_grant(id);
        chk("stall_grant", id, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'b100; req1_a = 10'd7; req1_b = 10'd8;
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", {rsp_id, rsp_data}, {1'b0, 10'd30});
            chk("stall_ready", {req0_ready, req1_ready}, 0);
            chk("stall_alu_a", alu_a, 10);
            chk("stall_busy", busy, 1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_drop", rsp_valid, 0);
        chk("release_grant", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("release_data", {rsp_id, rsp_data}, {1'b1, 10'd15});
        @(negedge clk);

        // Reset during EXEC discards the pending result.
        req0_valid = 1'b1; req0_op = 3'b100; req0_a = 10'd3; req0_b = 10'd5;
        #1;
        wait_grant(id);
        chk("rst6_grant", id, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst6_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
        chk("rst6_alu", {alu_op, alu_cal, alu_a, alu_b}, 0);
        chk("rst6_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("rst6_quiet", {rsp_valid, busy}, 0);
        end
        v = '{1'b1, 3'b100, 4'd0, 10'd3, 10'd5,
              1'b1, 3'b101, 4'd0, 10'd9, 10'd4, 0, 10'd8};
        run_vec(v);
        v = '{1'b0, 3'b100, 4'd0, 10'd3, 10'd5,
              1'b1, 3'b101, 4'd0, 10'd9, 10'd4, 1, 10'd5};
        run_vec(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
